// File: rtl/axi4_ram_slave_if.sv
// rtl/axi4_ram_slave_if.sv - reduced-signal AXI4 bus between the interconnect master port and the RAM slave
interface axi4_ram_slave_if #(
    parameter int ASIZE = 32,
    parameter int LSIZE = 8,
    parameter int DSIZE = 32
);
    logic [ASIZE-1:0] axi_awaddr;
    logic [LSIZE-1:0] axi_awlen;
    logic             axi_awvalid;
    logic             axi_awready;
    logic [DSIZE-1:0] axi_wdata;
    logic             axi_wlast;
    logic             axi_wvalid;
    logic             axi_wready;
    logic [1:0]       axi_bresp;
    logic             axi_bvalid;
    logic             axi_bready;
    logic [ASIZE-1:0] axi_araddr;
    logic [LSIZE-1:0] axi_arlen;
    logic             axi_arvalid;
    logic             axi_arready;
    logic [DSIZE-1:0] axi_rdata;
    logic             axi_rlast;
    logic             axi_rvalid;
    logic             axi_rready;

    modport master (
        output axi_awaddr, axi_awlen, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_araddr, axi_arlen, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rlast, axi_rvalid,
        output axi_rready
    );

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_araddr, axi_arlen, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rlast, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/axi4_ram_slave.sv
// rtl/axi4_ram_slave.sv - AXI4 burst responder on a dual-port RAM; AXI4_RAM_SLAVE_LAST_CHECK_EN enables wlast checking
module axi4_ram_slave #(
    parameter int ASIZE = 32,
    parameter int LSIZE = 8,
    parameter int DSIZE = 32,
    parameter int DEPTH = 1024
) (
    input logic             clock,
    input logic             rst,
    axi4_ram_slave_if.slave axi
);
    localparam int             RAW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ASIZE:0] DEPTH_EXT = (ASIZE+1)'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DSIZE-1:0] r_mem [DEPTH];

    // write path
    wstate_t          r_wstate;
    wstate_t          w_wstate_next;
    logic [ASIZE-1:0] r_waddr;
    logic [LSIZE-1:0] r_wlen;
    logic [LSIZE-1:0] r_wbeat;
    logic             r_werr;
    logic             w_awready;
    logic             w_wready;
    logic             w_bvalid;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_wfinal;
    logic             w_wbeat_oor;
    logic             w_wlast_bad;
    logic [ASIZE:0]   w_wbeat_addr;

    // read path
    rstate_t          r_rstate;
    rstate_t          w_rstate_next;
    logic [ASIZE-1:0] r_raddr;
    logic [LSIZE-1:0] r_rlen;
    logic [LSIZE-1:0] r_rissue;
    logic             r_rissue_done;
    logic [DSIZE-1:0] r_fifo_data [2];
    logic [1:0]       r_fifo_last;
    logic             r_fwr;
    logic             r_frd;
    logic [1:0]       r_fcount;
    logic             w_arready;
    logic             w_rvalid;
    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_issue;
    logic             w_rbeat_oor;
    logic [ASIZE:0]   w_rbeat_addr;

    // Beat addresses carry one extra bit so start+beat never wraps back into range.
    assign w_wbeat_addr = {1'b0, r_waddr} + (ASIZE+1)'(r_wbeat);
    assign w_wbeat_oor  = (w_wbeat_addr >= DEPTH_EXT);
    assign w_wfinal     = (r_wbeat == r_wlen);
    assign w_aw_hs      = axi.axi_awvalid & w_awready;
    assign w_w_hs       = axi.axi_wvalid & w_wready;

`ifdef AXI4_RAM_SLAVE_LAST_CHECK_EN
    assign w_wlast_bad = (axi.axi_wlast != w_wfinal);
`else
    logic w_unused_wlast;
    assign w_unused_wlast = axi.axi_wlast;
    assign w_wlast_bad    = 1'b0;
`endif

    assign axi.axi_awready = w_awready;
    assign axi.axi_wready  = w_wready;
    assign axi.axi_bvalid  = w_bvalid;
    assign axi.axi_bresp   = {w_bvalid & r_werr, 1'b0};

    // Write FSM state register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_next;
    end

    // Write FSM next state and handshake outputs; the burst ends on beat count only.
    always_comb begin
        w_wstate_next = r_wstate;
        w_awready     = 1'b0;
        w_wready      = 1'b0;
        w_bvalid      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (axi.axi_awvalid) w_wstate_next = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (axi.axi_wvalid && w_wfinal) w_wstate_next = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (axi.axi_bready) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Latch the write burst and track beat count plus the sticky error flag.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_waddr <= '0;
            r_wlen  <= '0;
            r_wbeat <= '0;
            r_werr  <= 1'b0;
        end else if (w_aw_hs) begin
            r_waddr <= axi.axi_awaddr;
            r_wlen  <= axi.axi_awlen;
            r_wbeat <= '0;
            r_werr  <= 1'b0;
        end else if (w_w_hs) begin
            r_wbeat <= r_wbeat + LSIZE'(1);
            r_werr  <= r_werr | w_wbeat_oor | w_wlast_bad;
        end
    end

    // RAM write port; out-of-range beats are accepted but dropped.
    always_ff @(posedge clock) begin
        if (w_w_hs && !w_wbeat_oor) r_mem[w_wbeat_addr[RAW-1:0]] <= axi.axi_wdata;
    end

    assign w_rbeat_addr = {1'b0, r_raddr} + (ASIZE+1)'(r_rissue);
    assign w_rbeat_oor  = (w_rbeat_addr >= DEPTH_EXT);
    assign w_ar_hs      = axi.axi_arvalid & w_arready;
    assign w_rvalid     = (r_fcount != 2'd0);
    assign w_r_hs       = w_rvalid & axi.axi_rready;
    // Issue a RAM read whenever the skid buffer will have room after this cycle's pop.
    assign w_issue      = (r_rstate == R_DATA) && !r_rissue_done &&
                          ((r_fcount != 2'd2) || w_r_hs);

    assign axi.axi_arready = w_arready;
    assign axi.axi_rvalid  = w_rvalid;
    assign axi.axi_rdata   = w_rvalid ? r_fifo_data[r_frd] : '0;
    assign axi.axi_rlast   = w_rvalid & r_fifo_last[r_frd];

    // Read FSM state register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_next;
    end

    // Read FSM next state; leave the burst once the rlast beat is taken.
    always_comb begin
        w_rstate_next = r_rstate;
        w_arready     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (axi.axi_arvalid) w_rstate_next = R_DATA;
            end
            R_DATA: begin
                if (w_r_hs && r_fifo_last[r_frd]) w_rstate_next = R_IDLE;
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Read burst bookkeeping: issue counter and skid buffer pointers/occupancy.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_raddr       <= '0;
            r_rlen        <= '0;
            r_rissue      <= '0;
            r_rissue_done <= 1'b0;
            r_fifo_last   <= '0;
            r_fwr         <= 1'b0;
            r_frd         <= 1'b0;
            r_fcount      <= '0;
        end else begin
            if (w_ar_hs) begin
                r_raddr       <= axi.axi_araddr;
                r_rlen        <= axi.axi_arlen;
                r_rissue      <= '0;
                r_rissue_done <= 1'b0;
                r_fwr         <= 1'b0;
                r_frd         <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_rissue           <= r_rissue + LSIZE'(1);
                    r_rissue_done      <= (r_rissue == r_rlen);
                    r_fifo_last[r_fwr] <= (r_rissue == r_rlen);
                    r_fwr              <= ~r_fwr;
                end
                if (w_r_hs) r_frd <= ~r_frd;
            end
            case ({w_issue, w_r_hs})
                2'b10:   r_fcount <= r_fcount + 2'd1;
                2'b01:   r_fcount <= r_fcount - 2'd1;
                default: r_fcount <= r_fcount;
            endcase
        end
    end

    // RAM read port straight into the skid buffer; read-first against same-cycle writes.
    always_ff @(posedge clock) begin
        if (w_issue) r_fifo_data[r_fwr] <= w_rbeat_oor ? '0 : r_mem[w_rbeat_addr[RAW-1:0]];
    end
endmodule

// File: tb/tb_axi4_ram_slave.sv
// tb/tb_axi4_ram_slave.sv - directed scoreboard bench for axi4_ram_slave
`timescale 1ns/1ps
module tb_axi4_ram_slave;
    localparam int ASIZE = 32;
    localparam int LSIZE = 8;
    localparam int DSIZE = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_ram_slave_if #(.ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)) axi ();

    axi4_ram_slave #(.ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
        .clock (clk),
        .rst   (rst),
        .axi   (axi.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [DSIZE-1:0] model [DEPTH];
    logic [DSIZE-1:0] wbuf  [256];
    logic [DSIZE-1:0] exp_q [$];

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chkd(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ASIZE-1:0] addr, input int len, input int wlast_at);
        logic           err;
        logic [ASIZE:0] ba;
        int             n;
        err = 1'b0;
        axi.axi_awaddr  = addr;
        axi.axi_awlen   = LSIZE'(len);
        axi.axi_awvalid = 1'b1;
        n = 0;
        while (axi.axi_awready !== 1'b1 && n < 20) begin step(); n++; end
        chk1("awready_wait", axi.axi_awready, 1'b1);
        step();
        axi.axi_awvalid = 1'b0;
        chk1("wready_after_aw", axi.axi_wready, 1'b1);
        for (int i = 0; i <= len; i++) begin
            axi.axi_wdata  = wbuf[i];
            axi.axi_wlast  = (i == wlast_at);
            axi.axi_wvalid = 1'b1;
            chk1("wready_beat", axi.axi_wready, 1'b1);
            chk1("bvalid_early", axi.axi_bvalid, 1'b0);
            ba = {1'b0, addr} + 33'(i);
            if (ba < 33'(DEPTH)) model[ba[9:0]] = wbuf[i];
            else                 err = 1'b1;
            step();
        end
        axi.axi_wvalid = 1'b0;
        axi.axi_wlast  = 1'b0;
`ifdef AXI4_RAM_SLAVE_LAST_CHECK_EN
        if (wlast_at != len) err = 1'b1;
`endif
        chk1("bvalid_after_last_w", axi.axi_bvalid, 1'b1);
        chkd("bresp", {30'b0, axi.axi_bresp}, err ? 32'd2 : 32'd0);
        axi.axi_bready = 1'b1;
        step();
        axi.axi_bready = 1'b0;
        chk1("awready_after_b", axi.axi_awready, 1'b1);
        chk1("bvalid_after_b", axi.axi_bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [ASIZE-1:0] addr, input int len, input bit toggle);
        logic [ASIZE:0]   ba;
        logic [DSIZE-1:0] held_d;
        logic [DSIZE-1:0] e;
        logic             held_l;
        bit               hold;
        int               beats;
        int               k;
        for (int i = 0; i <= len; i++) begin
            ba = {1'b0, addr} + 33'(i);
            exp_q.push_back((ba < 33'(DEPTH)) ? model[ba[9:0]] : '0);
        end
        axi.axi_araddr  = addr;
        axi.axi_arlen   = LSIZE'(len);
        axi.axi_arvalid = 1'b1;
        chk1("arready_idle", axi.axi_arready, 1'b1);
        step();
        axi.axi_arvalid = 1'b0;
        chk1("rvalid_one_after_ar", axi.axi_rvalid, 1'b0);
        step();
        chk1("rvalid_two_after_ar", axi.axi_rvalid, 1'b1);
        beats  = 0;
        k      = 0;
        hold   = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (beats <= len && k < 4 * len + 20) begin
            axi.axi_rready = toggle ? (k % 2 == 0) : 1'b1;
            if (hold) begin
                chkd("rdata_stable", axi.axi_rdata, held_d);
                chk1("rlast_stable", axi.axi_rlast, held_l);
            end
            if (!toggle) chk1("rvalid_no_bubble", axi.axi_rvalid, 1'b1);
            hold = 1'b0;
            if (axi.axi_rvalid === 1'b1) begin
                if (axi.axi_rready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    chkd("rdata", axi.axi_rdata, e);
                    chk1("rlast", axi.axi_rlast, beats == len);
                    beats++;
                end else begin
                    hold   = 1'b1;
                    held_d = axi.axi_rdata;
                    held_l = axi.axi_rlast;
                end
            end
            step();
            k++;
        end
        axi.axi_rready = 1'b0;
        chkd("read_beat_count", 32'(beats), 32'(len + 1));
        chkd("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk1("arready_after_rlast", axi.axi_arready, 1'b1);
        chk1("rvalid_after_rlast", axi.axi_rvalid, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        axi.axi_awaddr  = '0;
        axi.axi_awlen   = '0;
        axi.axi_awvalid = 1'b0;
        axi.axi_wdata   = '0;
        axi.axi_wlast   = 1'b0;
        axi.axi_wvalid  = 1'b0;
        axi.axi_bready  = 1'b0;
        axi.axi_araddr  = '0;
        axi.axi_arlen   = '0;
        axi.axi_arvalid = 1'b0;
        axi.axi_rready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_awready", axi.axi_awready, 1'b1);
        chk1("rst_wready", axi.axi_wready, 1'b0);
        chk1("rst_bvalid", axi.axi_bvalid, 1'b0);
        chkd("rst_bresp", {30'b0, axi.axi_bresp}, 32'd0);
        chk1("rst_arready", axi.axi_arready, 1'b1);
        chk1("rst_rvalid", axi.axi_rvalid, 1'b0);
        chk1("rst_rlast", axi.axi_rlast, 1'b0);
        chkd("rst_rdata", axi.axi_rdata, 32'd0);
        rst = 1'b0;
        step();

        // basic 4-beat burst, read back with rready high then toggling
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(32'h10, 3, 3);
        do_read(32'h10, 3, 1'b0);
        do_read(32'h10, 3, 1'b1);

        // burst running past the top of the RAM
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + 32'(i);
        do_write(32'd1022, 3, 3);
        do_read(32'd1022, 3, 1'b0);
        do_read(32'd1022, 3, 1'b1);

        // early wlast on beat 2
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
        do_write(32'h40, 3, 2);
        do_read(32'h40, 3, 0);

        // maximum burst length, single beat bursts
        for (int i = 0; i < 256; i++) wbuf[i] = 32'h5000_0000 + 32'(i * 3);
        do_write(32'd300, 255, 255);
        do_read(32'd300, 255, 1'b0);
        do_read(32'd301, 0, 1'b0);
        wbuf[0] = 32'h7777_0001;
        do_write(32'd0, 0, 0);
        do_read(32'd0, 0, 1'b1);

        // asynchronous reset in the middle of a read burst
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hE0 + 32'(i);
        do_write(32'd200, 7, 7);
        axi.axi_araddr  = 32'd200;
        axi.axi_arlen   = 8'd7;
        axi.axi_arvalid = 1'b1;
        step();
        axi.axi_arvalid = 1'b0;
        axi.axi_rready  = 1'b1;
        step();
        chkd("pre_rst_beat0", axi.axi_rdata, 32'hE0);
        step();
        step();
        chkd("pre_rst_beat2", axi.axi_rdata, 32'hE2);
        #2;
        rst = 1'b1;
        #1;
        chk1("midrst_rvalid", axi.axi_rvalid, 1'b0);
        chk1("midrst_rlast", axi.axi_rlast, 1'b0);
        chkd("midrst_rdata", axi.axi_rdata, 32'd0);
        chk1("midrst_arready", axi.axi_arready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk1("inrst_rvalid", axi.axi_rvalid, 1'b0);
        rst = 1'b0;
        axi.axi_rready = 1'b0;
        step();
        chk1("postrst_arready", axi.axi_arready, 1'b1);
        chk1("postrst_awready", axi.axi_awready, 1'b1);
        chk1("postrst_rvalid", axi.axi_rvalid, 1'b0);
        do_read(32'd200, 7, 1'b0);

        // same-cycle write and read of one address returns the old value
        wbuf[0] = 32'h11;
        do_write(32'd5, 0, 0);
        axi.axi_awaddr  = 32'd5;
        axi.axi_awlen   = 8'd0;
        axi.axi_awvalid = 1'b1;
        axi.axi_araddr  = 32'd5;
        axi.axi_arlen   = 8'd0;
        axi.axi_arvalid = 1'b1;
        chk1("rf_awready", axi.axi_awready, 1'b1);
        chk1("rf_arready", axi.axi_arready, 1'b1);
        step();
        axi.axi_awvalid = 1'b0;
        axi.axi_arvalid = 1'b0;
        axi.axi_wdata   = 32'h22;
        axi.axi_wlast   = 1'b1;
        axi.axi_wvalid  = 1'b1;
        axi.axi_rready  = 1'b1;
        chk1("rf_wready", axi.axi_wready, 1'b1);
        step();
        axi.axi_wvalid = 1'b0;
        axi.axi_wlast  = 1'b0;
        chk1("rf_rvalid", axi.axi_rvalid, 1'b1);
        chkd("rf_old_data", axi.axi_rdata, 32'h11);
        chk1("rf_rlast", axi.axi_rlast, 1'b1);
        chk1("rf_bvalid", axi.axi_bvalid, 1'b1);
        chkd("rf_bresp", {30'b0, axi.axi_bresp}, 32'd0);
        axi.axi_bready = 1'b1;
        step();
        axi.axi_bready = 1'b0;
        axi.axi_rready = 1'b0;
        chk1("rf_arready_after", axi.axi_arready, 1'b1);
        chk1("rf_awready_after", axi.axi_awready, 1'b1);
        model[5] = 32'h22;
        do_read(32'd5, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_ram_slave.md
# axi4_ram_slave

AXI4 burst responder backed by an on-chip dual-port RAM. It terminates the single master port of the many-to-one AXI4 interconnect. It is the slave end used in simulation and as a scratch frame store for VDMA bring-up. Write (AW/W/B) and read (AR/R) paths run as independent state machines on separate RAM ports, using the same reduced signal set the interconnect drives: addr, len, data, last, bresp; no id, size, strobe or rresp.

## Interface
Parameters:
- ASIZE, 32, address width in words (one address = one DSIZE beat)
- LSIZE, 8, burst length field width; beats = len+1
- DSIZE, 32, data width
- DEPTH, 1024, RAM depth in words; valid addresses 0..DEPTH-1

Ports:
- clock  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- axi_awaddr  in  ASIZE  write burst start address
- axi_awlen  in  LSIZE  write burst length-1
- axi_awvalid / axi_awready  in / out  1  AW handshake
- axi_wdata  in  DSIZE  write data
- axi_wlast  in  1  final write beat marker
- axi_wvalid / axi_wready  in / out  1  W handshake
- axi_bresp  out  2  00 OKAY, 10 SLVERR
- axi_bvalid / axi_bready  out / in  1  B handshake
- axi_araddr  in  ASIZE  read burst start address
- axi_arlen  in  LSIZE  read burst length-1
- axi_arvalid / axi_arready  in / out  1  AR handshake
- axi_rdata  out  DSIZE  read data
- axi_rlast  out  1  final read beat marker
- axi_rvalid / axi_rready  out / in  1  R handshake

## Operation
- Reset values: awready=1, wready=0, bvalid=0, bresp=00, arready=1, rvalid=0, rlast=0, rdata=0. RAM contents are not cleared.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch addr/len, clear the beat counter and error flag, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes wdata to RAM[addr+beat] and increments the beat counter. Beat len is the final beat; it moves the FSM to W_RESP.
  - W_RESP: bvalid=1 with bresp held until bready, then go to W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch addr/len, go to R_DATA.
  - R_DATA: RAM reads are issued into a 2-entry output skid buffer; rvalid reflects buffer non-empty. rlast is set on beat len.
  - After the rlast handshake, go to R_IDLE.
- Address arithmetic: the beat address is start+beat, computed ASIZE+1 bits wide, so it never wraps back into range.
  - A beat address ≥ DEPTH is out of range.
  - Out-of-range write beats are still accepted (wready=1) but dropped, and set the error flag → bresp=10.
  - Out-of-range read beats return rdata=0.
- Same-address read and write in the same cycle: the read returns the old RAM value (read-first).
- The write and read paths never stall each other.

## Timing
- AW handshake at cycle T → wready=1 at T+1.
- Final W handshake at cycle T → bvalid=1 at T+1. B handshake at T → awready=1 at T+1.
- AR handshake at cycle T → first rvalid at T+2 (address registered at T+1, RAM data at T+2).
- With rready held high, one beat per cycle and no bubbles.
- rready low: rdata/rlast stay stable, no beat is lost or duplicated, and at most 2 beats are prefetched.
- rlast handshake at T → arready=1 at T+1. Back-to-back bursts have a 1-cycle gap.
- rst assertion mid-burst: all outputs take their reset values immediately (asynchronous). The burst is abandoned and the FSMs restart in IDLE after release.
- awlen=0 and arlen=0 are legal single-beat bursts. len=2^LSIZE-1 must work with no counter overflow (the beat counter is LSIZE bits and compares against len).

## Configuration
- AXI4_RAM_SLAVE_LAST_CHECK_EN defined:
  - wlast must equal (beat==len) on every W beat; any mismatch sets the error flag → bresp=10.
  - The burst still ends on beat count, never on an early wlast.
- Macro undefined: wlast is ignored; bresp reflects the out-of-range condition only.

## Test plan
- Write awaddr=0x10, awlen=3, data A0..A3 → bvalid one cycle after the 4th beat with bresp=00. Read araddr=0x10, arlen=3 → A0,A1,A2,A3, rlast on the 4th beat, first rvalid 2 cycles after AR handshake.
- Same read with rready toggling 1,0,1,0… → exactly A0..A3 in order, rdata stable while rready=0.
- DEPTH=1024: write awaddr=1022, awlen=3, data D0..D3 → bresp=10, RAM[1022]=D0, RAM[1023]=D1. Read araddr=1022, arlen=3 → D0,D1,0,0.
- Write awlen=3 with wlast on beat 2 → bresp=10 when AXI4_RAM_SLAVE_LAST_CHECK_EN is defined, 00 without it; 4 beats accepted in both cases.
- rst pulsed during beat 2 of an arlen=7 read → rvalid=0 during reset, arready=1 after release; a re-read returns the previously written data.
- RAM[5]=0x11; write 0x22 to addr 5 in the same cycle that the read of addr 5 is issued → read returns 0x11; a following read returns 0x22.
